// File: rtl/key_search_if.sv
// rtl/key_search_if.sv - dispatcher-to-decrypt-core key handoff bundle.
interface key_search_if #(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = 24
);
    logic [NUM_CORES-1:0]           core_ready;
    logic [NUM_CORES-1:0]           core_done;
    logic [NUM_CORES-1:0]           core_match;
    logic [NUM_CORES-1:0]           core_start;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
    logic                           stop_all;

    modport master (
        input  core_ready, core_done, core_match,
        output core_start, core_key, stop_all
    );

    modport slave (
        output core_ready, core_done, core_match,
        input  core_start, core_key, stop_all
    );
endinterface

// File: rtl/key_search_dispatcher.sv
// rtl/key_search_dispatcher.sv - round-robin key issue to RC4 cores, match/exhaustion verdict.
module key_search_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MIN = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX = KEY_WIDTH'(24'h3FFFFF)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    key_search_if.master         cores,
    output logic                 busy,
    output logic                 success,
    output logic                 total_failure,
    output logic [KEY_WIDTH-1:0] secret_key
);
    localparam int RW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED} state_t;

    state_t                         state, state_d;
    logic [KEY_WIDTH:0]             next_key, next_key_d;
    logic [NUM_CORES-1:0]           outstanding, outstanding_d;
    logic [RW-1:0]                  rr, rr_d;
    logic [NUM_CORES-1:0]           start_d;
    logic [NUM_CORES*KEY_WIDTH-1:0] key_d;
    logic                           stop_d, success_d, failure_d, busy_d;
    logic [KEY_WIDTH-1:0]           secret_d;
    logic [NUM_CORES-1:0]           eligible, valid_match;
    logic                           grant_found, match_found;
    int                             grant_idx, match_idx, cand;

    always_comb begin
        eligible    = cores.core_ready & ~outstanding;
        valid_match = cores.core_done & cores.core_match & outstanding;

        grant_found = 1'b0;
        grant_idx   = 0;
        cand        = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = (int'(rr) + k) % NUM_CORES;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end

        // Scan downward so the lowest matching index is the one kept.
        match_found = 1'b0;
        match_idx   = 0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (valid_match[i]) begin
                match_found = 1'b1;
                match_idx   = i;
            end
        end

        state_d       = state;
        next_key_d    = next_key;
        outstanding_d = outstanding;
        rr_d          = rr;
        start_d       = '0;
        key_d         = cores.core_key;
        stop_d        = cores.stop_all;
        success_d     = success;
        failure_d     = total_failure;
        secret_d      = secret_key;

        case (state)
            IDLE, FOUND, EXHAUSTED: begin
                if (go) begin
                    state_d       = DISPATCH;
                    next_key_d    = {1'b0, KEY_MIN};
                    outstanding_d = '0;
                    rr_d          = '0;
                    stop_d        = 1'b0;
                    success_d     = 1'b0;
                    failure_d     = 1'b0;
                    secret_d      = '0;
                end
            end
            DISPATCH, DRAIN: begin
                outstanding_d = outstanding & ~cores.core_done;
                if (match_found) begin
                    state_d   = FOUND;
                    success_d = 1'b1;
                    stop_d    = 1'b1;
                    secret_d  = cores.core_key[match_idx*KEY_WIDTH +: KEY_WIDTH];
                end else if (state == DISPATCH) begin
                    if (grant_found) begin
                        start_d[grant_idx]                     = 1'b1;
                        key_d[grant_idx*KEY_WIDTH +: KEY_WIDTH] = next_key[KEY_WIDTH-1:0];
                        outstanding_d[grant_idx]               = 1'b1;
                        next_key_d                             = next_key + 1'b1;
                        rr_d                                   = RW'((grant_idx + 1) % NUM_CORES);
                        if (next_key == {1'b0, KEY_MAX}) begin
                            state_d = DRAIN;
                        end
                    end
                end else if (outstanding == '0) begin
                    state_d   = EXHAUSTED;
                    failure_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == DISPATCH) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            next_key         <= {1'b0, KEY_MIN};
            outstanding      <= '0;
            rr               <= '0;
            cores.core_start <= '0;
            cores.core_key   <= '0;
            cores.stop_all   <= 1'b0;
            busy             <= 1'b0;
            success          <= 1'b0;
            total_failure    <= 1'b0;
            secret_key       <= '0;
        end else begin
            state            <= state_d;
            next_key         <= next_key_d;
            outstanding      <= outstanding_d;
            rr               <= rr_d;
            cores.core_start <= start_d;
            cores.core_key   <= key_d;
            cores.stop_all   <= stop_d;
            busy             <= busy_d;
            success          <= success_d;
            total_failure    <= failure_d;
            secret_key       <= secret_d;
        end
    end
endmodule

// File: tb/tb_key_search_dispatcher.sv
// tb/tb_key_search_dispatcher.sv - scenario table, reset and random runs against a key-space model.
module tb_key_search_dispatcher;
    localparam int N  = 4;
    localparam int KW = 24;
    localparam int S_IDLE = 0, S_DISP = 1, S_DRAIN = 2, S_FOUND = 3, S_EXH = 4;

    logic clk = 1'b0;
    logic reset, go_a, go_b, sel;
    logic [N-1:0] ready, done, match;
    logic busy_a, succ_a, fail_a, busy_b, succ_b, fail_b;
    logic [KW-1:0] sec_a, sec_b;

    key_search_if #(.NUM_CORES(N), .KEY_WIDTH(KW)) ia ();
    key_search_if #(.NUM_CORES(N), .KEY_WIDTH(KW)) ib ();

    assign ia.core_ready = ready;
    assign ia.core_done  = done;
    assign ia.core_match = match;
    assign ib.core_ready = ready;
    assign ib.core_done  = done;
    assign ib.core_match = match;

    key_search_dispatcher #(.NUM_CORES(N), .KEY_WIDTH(KW), .KEY_MIN(24'd0), .KEY_MAX(24'd7)) dut_a (
        .clk(clk), .reset(reset), .go(go_a), .cores(ia.master),
        .busy(busy_a), .success(succ_a), .total_failure(fail_a), .secret_key(sec_a));

    key_search_dispatcher #(.NUM_CORES(N), .KEY_WIDTH(KW), .KEY_MIN(24'd0), .KEY_MAX(24'd15)) dut_b (
        .clk(clk), .reset(reset), .go(go_b), .cores(ib.master),
        .busy(busy_b), .success(succ_b), .total_failure(fail_b), .secret_key(sec_b));

    always #5 clk = ~clk;

    wire [N-1:0]    o_start = sel ? ib.core_start : ia.core_start;
    wire [N*KW-1:0] o_key   = sel ? ib.core_key   : ia.core_key;
    wire            o_stop  = sel ? ib.stop_all   : ia.stop_all;
    wire            o_busy  = sel ? busy_b : busy_a;
    wire            o_succ  = sel ? succ_b : succ_a;
    wire            o_fail  = sel ? fail_b : fail_a;
    wire [KW-1:0]   o_sec   = sel ? sec_b  : sec_a;
    wire            o_go    = sel ? go_b   : go_a;

    int vectors = 0;
    int errors  = 0;

    // Reference model: search phase, key counter, cores holding an unanswered key.
    int m_state, m_next, m_rr, m_kmax, m_secret;
    logic [N-1:0] m_out;
    int m_key[N];

    // Core models and current scenario knobs.
    int cnt[N], ckey[N];
    int cur_lat, cur_slow, cur_mk0, cur_mk1, cur_stray, cyc, nstarts;
    logic [N-1:0] cur_rdy;
    bit rnd;

    typedef struct {
        bit         use_b;
        int         lat;
        int         slow_key;
        int         mk0;
        int         mk1;
        logic [3:0] rdy;
        int         stray;
        bit         exp_succ;
        bit         exp_fail;
        int         exp_secret;
        int         exp_starts;
    } scen_t;

    scen_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_match(int k);
        return (k == cur_mk0) || (k == cur_mk1);
    endfunction

    task automatic step();
        logic [N-1:0] grant, vm, elig;
        int g, l;
        @(posedge clk);
        #1;
        grant = '0;
        g     = 0;
        case (m_state)
            S_DISP, S_DRAIN: begin
                vm = done & match & m_out;
                if (vm != '0) begin
                    for (int i = N - 1; i >= 0; i--) if (vm[i]) g = i;
                    m_secret = m_key[g];
                    m_state  = S_FOUND;
                end else if (m_state == S_DISP) begin
                    elig = ready & ~m_out;
                    g = -1;
                    for (int k = 0; k < N; k++)
                        if (g < 0 && elig[(m_rr + k) % N]) g = (m_rr + k) % N;
                    if (g >= 0) begin
                        grant[g] = 1'b1;
                        m_key[g] = m_next;
                        m_rr     = (g + 1) % N;
                        if (m_next == m_kmax) m_state = S_DRAIN;
                        m_next++;
                    end
                end else if (m_out == '0) begin
                    m_state = S_EXH;
                end
                m_out = (m_out & ~done) | grant;
            end
            default: begin
                if (o_go) begin
                    m_state  = S_DISP;
                    m_next   = 0;
                    m_out    = '0;
                    m_rr     = 0;
                    m_secret = 0;
                end
            end
        endcase

        check("core_start", o_start, grant);
        if (grant != '0) check("core_key", o_key[g*KW +: KW], m_next - 1);
        check("success", o_succ, m_state == S_FOUND);
        check("total_failure", o_fail, m_state == S_EXH);
        check("stop_all", o_stop, m_state == S_FOUND);
        check("busy", o_busy, (m_state == S_DISP) || (m_state == S_DRAIN));
        check("secret_key", o_sec, (m_state == S_FOUND) ? m_secret : 0);
        nstarts += $countones(o_start);
        cyc++;

        go_a = 1'b0;
        go_b = 1'b0;
        for (int i = 0; i < N; i++) begin
            done[i]  = 1'b0;
            match[i] = 1'b0;
            if (o_stop) begin
                cnt[i] = 0;
            end else if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    done[i]  = 1'b1;
                    match[i] = is_match(ckey[i]);
                end
            end
            if (o_start[i]) begin
                ckey[i] = int'(o_key[i*KW +: KW]);
                l = rnd ? int'($urandom_range(1, 6)) : ((ckey[i] == cur_slow) ? cur_lat + 2 : cur_lat);
                if (l <= 1) begin
                    done[i]  = 1'b1;
                    match[i] = is_match(ckey[i]);
                end else begin
                    cnt[i] = l - 1;
                end
            end
            // Stray verdicts from cores holding no key must be ignored.
            if (!m_out[i] && !done[i] && cnt[i] == 0 &&
                ((i == 0 && cyc == cur_stray) || (rnd && $urandom_range(0, 7) == 0))) begin
                done[i]  = 1'b1;
                match[i] = 1'b1;
            end
        end
        ready = rnd ? N'($urandom_range(0, 15)) : cur_rdy;
    endtask

    task automatic start_run(input bit use_b);
        sel     = use_b;
        m_kmax  = use_b ? 15 : 7;
        cyc     = 0;
        nstarts = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        done  = '0;
        match = '0;
        ready = rnd ? N'($urandom_range(0, 15)) : cur_rdy;
        if (use_b) go_b = 1'b1;
        else       go_a = 1'b1;
    endtask

    task automatic finish_run(input int max_cyc);
        int extra = 0;
        for (int c = 0; c < max_cyc && extra < 4; c++) begin
            step();
            if (m_state == S_FOUND || m_state == S_EXH) extra++;
        end
        check("run_completed", extra, 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //        b  lat slow mk0 mk1 rdy     stray succ fail secret starts
        tbl[0] = '{0, 3, -1, -1, -1, 4'hF,   -1,  0,  1,   0,     8};
        tbl[1] = '{0, 3, -1,  5, -1, 4'hF,   -1,  1,  0,   5,     8};
        tbl[2] = '{0, 3, -1,  7, -1, 4'hF,   -1,  1,  0,   7,     8};
        tbl[3] = '{0, 6, -1,  2, -1, 4'hF,   -1,  1,  0,   2,     5};
        tbl[4] = '{1, 3,  9,  9, 11, 4'hF,   -1,  1,  0,   9,    13};
        tbl[5] = '{0, 6, -1, -1, -1, 4'b0100, 3,  0,  1,   0,     8};

        reset = 1'b1;
        go_a  = 1'b0;
        go_b  = 1'b0;
        sel   = 1'b0;
        ready = '0;
        done  = '0;
        match = '0;
        rnd   = 1'b0;
        m_state = S_IDLE;
        m_out   = '0;
        m_next = 0; m_rr = 0; m_secret = 0; m_kmax = 7;
        for (int i = 0; i < N; i++) begin m_key[i] = 0; cnt[i] = 0; ckey[i] = 0; end

        repeat (2) @(posedge clk);
        #1;
        check("rst_start_a", ia.core_start, 0);
        check("rst_key_a", ia.core_key, 0);
        check("rst_stop_a", ia.stop_all, 0);
        check("rst_flags_a", {busy_a, succ_a, fail_a}, 0);
        check("rst_secret_a", sec_a, 0);
        check("rst_outs_b", {ib.core_start, ib.stop_all, busy_b, succ_b, fail_b}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int s = 0; s < 6; s++) begin
            rnd       = 1'b0;
            cur_lat   = tbl[s].lat;
            cur_slow  = tbl[s].slow_key;
            cur_mk0   = tbl[s].mk0;
            cur_mk1   = tbl[s].mk1;
            cur_rdy   = tbl[s].rdy;
            cur_stray = tbl[s].stray;
            start_run(tbl[s].use_b);
            finish_run(200);
            check($sformatf("s%0d success", s), o_succ, tbl[s].exp_succ);
            check($sformatf("s%0d total_failure", s), o_fail, tbl[s].exp_fail);
            check($sformatf("s%0d secret_key", s), o_sec, tbl[s].exp_secret);
            check($sformatf("s%0d starts", s), nstarts, tbl[s].exp_starts);
            check($sformatf("s%0d busy", s), o_busy, 0);
        end

        // Reset in the middle of dispatch, right after key 4 goes out.
        rnd = 1'b0; cur_lat = 3; cur_slow = -1; cur_mk0 = -1; cur_mk1 = -1;
        cur_rdy = 4'hF; cur_stray = -1;
        start_run(1'b0);
        for (int c = 0; c < 30 && nstarts < 5; c++) step();
        check("reached_key4", nstarts, 5);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_start", ia.core_start, 0);
        check("async_rst_stop", ia.stop_all, 0);
        check("async_rst_key", ia.core_key, 0);
        check("async_rst_flags", {busy_a, succ_a, fail_a}, 0);
        check("async_rst_secret", sec_a, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        m_state = S_IDLE;
        m_out   = '0;
        start_run(1'b0);
        step();
        step();
        check("post_reset_start", o_start, 4'b0001);
        check("post_reset_key", o_key[KW-1:0], 0);
        finish_run(200);
        check("post_reset_exhausted", o_fail, 1);

        for (int r = 0; r < 8; r++) begin
            rnd       = 1'b1;
            cur_mk0   = int'($urandom_range(0, 8));
            cur_mk1   = -1;
            cur_slow  = -1;
            cur_stray = -1;
            start_run(1'b0);
            finish_run(400);
            check("rand_verdict", {o_succ, o_fail}, (cur_mk0 <= 7) ? 2'b10 : 2'b01);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
